// File: rtl/ifu_prefetch.sv
// Sequential instruction fetch unit with a DEPTH-entry {pc, instr} prefetch FIFO.
// Define IFU_STAT_EN to build the fetch/drop statistics counters.
module ifu_prefetch #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(64'h8000_0000),
  parameter int                DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_valid,
  input  logic              i_ram_ready,
  input  logic [31:0]       i_ram_rdata,
  output logic [2:0]        o_ram_size,
  input  logic              i_branch_jump,
  input  logic [ADDR_W-1:0] i_next_pc,
  input  logic              i_int_valid,
  input  logic [ADDR_W-1:0] i_int_addr,
  output logic [31:0]       o_instr,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_instr_valid,
  input  logic              i_instr_ready,
  output logic [31:0]       o_stat_fetch,
  output logic [31:0]       o_stat_drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  cnt_after_push;
  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [31:0]       instr_mem [DEPTH];

  logic              redirect;
  logic [ADDR_W-1:0] new_pc;
  logic              push;
  logic              pop;

  assign redirect       = i_int_valid | i_branch_jump;
  assign new_pc         = i_int_valid ? i_int_addr : i_next_pc;
  assign pop            = o_instr_valid & i_instr_ready;
  assign cnt_after_push = count_q + CNT_W'(1) - CNT_W'(pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = new_pc;
        end else if (count_q < DEPTH_C) begin
          state_d    = REQ;
          req_addr_d = fetch_pc_q;
        end
      end
      REQ: begin
        if (redirect) begin
          fetch_pc_d = new_pc;
          state_d    = i_ram_ready ? IDLE : DISCARD;
        end else if (i_ram_ready) begin
          fetch_pc_d = fetch_pc_q + ADDR_W'(4);
          req_addr_d = req_addr_q + ADDR_W'(4);
          if (cnt_after_push == DEPTH_C) state_d = IDLE;
        end
      end
      DISCARD: begin
        // The stale request cannot be withdrawn; only the resume point moves.
        if (redirect)    fetch_pc_d = new_pc;
        if (i_ram_ready) state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ram_valid   = (state_q == REQ) || (state_q == DISCARD);
    o_instr_valid = (count_q != '0) && !redirect;
    push          = (state_q == REQ) && i_ram_ready && !redirect;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      if (redirect) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // NOTE: FIFO storage is not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= req_addr_q;
      instr_mem[wr_ptr_q] <= i_ram_rdata;
    end
  end

  assign o_pc       = pc_mem[rd_ptr_q];
  assign o_instr    = instr_mem[rd_ptr_q];
  assign o_ram_addr = req_addr_q;
  assign o_ram_size = 3'b010;

`ifdef IFU_STAT_EN
  logic        drop;
  logic [31:0] stat_fetch_q, stat_drop_q;

  assign drop = i_ram_ready && (((state_q == REQ) && redirect) || (state_q == DISCARD));

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetch_q <= '0;
      stat_drop_q  <= '0;
    end else begin
      if (push) stat_fetch_q <= stat_fetch_q + 32'd1;
      if (drop) stat_drop_q  <= stat_drop_q + 32'd1;
    end
  end

  assign o_stat_fetch = stat_fetch_q;
  assign o_stat_drop  = stat_drop_q;
`else
  assign o_stat_fetch = '0;
  assign o_stat_drop  = '0;
`endif

endmodule
